// File: rtl/vga_scan_timer.sv
// VGA scan timing generator: divides the system clock to the pixel rate, publishes the scan
// position for the colour stage and registers the blanked colour together with hsync/vsync.
module vga_scan_timer #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned RGB_W     = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RGB_W-1:0] rgb_in,
   output logic             pixel_tick,
   output logic [9:0]       pixel_x,
   output logic [9:0]       pixel_y,
   output logic             video_on,
   output logic             frame_start,
   output logic             hsync,
   output logic             vsync,
   output logic [RGB_W-1:0] rgb_out
);

   localparam int unsigned CNT_W    = 10;
   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   logic [DIV_W-1:0] div_q;
   logic             x_last_c;
   logic             y_last_c;
   logic             hs_n_c;
   logic             vs_n_c;

   // Position decodes taken from the current counters.
   always_comb begin
      x_last_c = (pixel_x == CNT_W'(H_TOTAL - 1));
      y_last_c = (pixel_y == CNT_W'(V_TOTAL - 1));
      hs_n_c   = !((pixel_x >= CNT_W'(HS_START)) && (pixel_x < CNT_W'(HS_END)));
      vs_n_c   = !((pixel_y >= CNT_W'(VS_START)) && (pixel_y < CNT_W'(VS_END)));
   end

   assign pixel_tick = (div_q == DIV_W'(CLK_DIV - 1));
   assign video_on   = (pixel_x < CNT_W'(H_DISPLAY)) && (pixel_y < CNT_W'(V_DISPLAY));

   // Counters and output stage all advance together on the last clk of each pixel period,
   // so sync and colour stay aligned one pixel behind the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q       <= '0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         frame_start <= 1'b0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         rgb_out     <= '0;
      end else begin
         frame_start <= 1'b0;
         if (pixel_tick) begin
            div_q       <= '0;
            hsync       <= hs_n_c;
            vsync       <= vs_n_c;
            rgb_out     <= video_on ? rgb_in : '0;
            frame_start <= x_last_c && y_last_c;
            if (x_last_c) begin
               pixel_x <= '0;
               pixel_y <= y_last_c ? '0 : pixel_y + CNT_W'(1);
            end else begin
               pixel_x <= pixel_x + CNT_W'(1);
            end
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vga_scan_timer.sv
// Scoreboard bench for vga_scan_timer on a shrunken raster (25x15 pixels, 4 clks per pixel)
// so that several frames and a mid-frame reset fit in a short run.
module tb_vga_scan_timer;

   localparam int unsigned CLK_DIV   = 4;
   localparam int unsigned H_DISPLAY = 16;
   localparam int unsigned H_FRONT   = 2;
   localparam int unsigned H_SYNC    = 4;
   localparam int unsigned H_BACK    = 3;
   localparam int unsigned V_DISPLAY = 8;
   localparam int unsigned V_FRONT   = 2;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 3;
   localparam int unsigned RGB_W     = 12;

   // Hand-computed for the raster above: 25 pixels/line, 15 lines/frame.
   localparam int H_TOT        = 25;
   localparam int V_TOT        = 15;
   localparam int FRAME_CLKS   = 1500;
   localparam int HS_LOW_CLKS  = 16;
   localparam int VS_LOW_CLKS  = 200;

   typedef struct {
      int          p;
      int          x;
      int          y;
      int          hs;
      int          vs;
      int          rgb;
      int          von;
   } rec_t;

   logic             clk;
   logic             rst;
   logic [RGB_W-1:0] rgb_in;
   logic             pixel_tick;
   logic [9:0]       pixel_x;
   logic [9:0]       pixel_y;
   logic             video_on;
   logic             frame_start;
   logic             hsync;
   logic             vsync;
   logic [RGB_W-1:0] rgb_out;

   rec_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   run   = 1'b0;
   int   hs_cnt = 0;
   int   vs_cnt = 0;

   bit   have_prev = 1'b0;
   int   prev_x = 0;
   int   prev_y = 0;
   int   prev_rgb = 0;

   vga_scan_timer #(
      .CLK_DIV(CLK_DIV), .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC),
      .H_BACK(H_BACK), .V_DISPLAY(V_DISPLAY), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC),
      .V_BACK(V_BACK), .RGB_W(RGB_W)
   ) dut (
      .clk(clk), .rst(rst), .rgb_in(rgb_in), .pixel_tick(pixel_tick),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
      .frame_start(frame_start), .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected response for pixel p: counters show p, outputs show pixel p-1.
   task automatic push_rec(input int p, input int val);
      rec_t r;
      r.p   = p;
      r.x   = p % H_TOT;
      r.y   = (p / H_TOT) % V_TOT;
      r.von = (r.x < 16 && r.y < 8) ? 1 : 0;
      if (!have_prev) begin
         r.hs  = 1;
         r.vs  = 1;
         r.rgb = 0;
      end else begin
         r.hs  = (prev_x >= 18 && prev_x <= 21) ? 0 : 1;
         r.vs  = (prev_y >= 10 && prev_y <= 11) ? 0 : 1;
         r.rgb = (prev_x < 16 && prev_y < 8) ? prev_rgb : 0;
      end
      sb.push_back(r);
      have_prev = 1'b1;
      prev_x    = r.x;
      prev_y    = r.y;
      prev_rgb  = val;
   endtask

   // One pixel period: unsettled colour first, final colour on the sampling clk.
   task automatic do_pixel(input int p, input logic [RGB_W-1:0] val, input logic [RGB_W-1:0] junk);
      push_rec(p, int'(val));
      rgb_in = junk;
      repeat (3) @(posedge clk);
      #1 rgb_in = val;
      @(posedge clk);
      #1;
   endtask

   // Edges since reset release.
   initial forever begin
      @(posedge clk);
      cyc = run ? cyc + 1 : 0;
   end

   // Monitor: per-clk tick/frame checks, sync widths, and scoreboard pop on every pixel tick.
   initial forever begin
      @(negedge clk);
      if (!run) begin
         hs_cnt = 0;
         vs_cnt = 0;
      end else begin
         chk("pixel_tick", int'(pixel_tick), (cyc % CLK_DIV == CLK_DIV - 1) ? 1 : 0);
         chk("frame_start", int'(frame_start), (cyc > 0 && cyc % FRAME_CLKS == 0) ? 1 : 0);
         if (!hsync) hs_cnt++;
         else if (hs_cnt != 0) begin
            chk("hsync_low_clks", hs_cnt, HS_LOW_CLKS);
            hs_cnt = 0;
         end
         if (!vsync) vs_cnt++;
         else if (vs_cnt != 0) begin
            chk("vsync_low_clks", vs_cnt, VS_LOW_CLKS);
            vs_cnt = 0;
         end
         if (pixel_tick) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_underflow: got tick at cyc %0d, expected no tick", cyc);
            end else begin
               rec_t r;
               r = sb.pop_front();
               chk($sformatf("pixel_x@p%0d", r.p), int'(pixel_x), r.x);
               chk($sformatf("pixel_y@p%0d", r.p), int'(pixel_y), r.y);
               chk($sformatf("video_on@p%0d", r.p), int'(video_on), r.von);
               chk($sformatf("hsync@p%0d", r.p), int'(hsync), r.hs);
               chk($sformatf("vsync@p%0d", r.p), int'(vsync), r.vs);
               chk($sformatf("rgb_out@p%0d", r.p), int'(rgb_out), r.rgb);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [RGB_W-1:0] v;
      rst    = 1'b1;
      rgb_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pixel_x", int'(pixel_x), 0);
      chk("rst_pixel_y", int'(pixel_y), 0);
      chk("rst_hsync", int'(hsync), 1);
      chk("rst_vsync", int'(vsync), 1);
      chk("rst_rgb_out", int'(rgb_out), 0);
      chk("rst_video_on", int'(video_on), 1);
      chk("rst_pixel_tick", int'(pixel_tick), 0);
      chk("rst_frame_start", int'(frame_start), 0);

      rst = 1'b0;
      run = 1'b1;
      // First frame with constant white, then a varying pattern.
      for (int p = 0; p < 894; p++) begin
         if (p < 375) do_pixel(p, 12'hFFF, 12'hFFF);
         else begin
            v = RGB_W'(p * 37 + 5);
            do_pixel(p, v, ~v);
         end
      end

      // Reset at (19,5) while hsync is low, divider at 2.
      push_rec(894, 12'h123);
      rgb_in = 12'h123;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("pre_rst_pixel_x", int'(pixel_x), 19);
      chk("pre_rst_hsync", int'(hsync), 0);
      run = 1'b0;
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      chk("mid_rst_hsync", int'(hsync), 1);
      chk("mid_rst_vsync", int'(vsync), 1);
      chk("mid_rst_pixel_x", int'(pixel_x), 0);
      chk("mid_rst_pixel_y", int'(pixel_y), 0);
      chk("mid_rst_rgb_out", int'(rgb_out), 0);
      chk("mid_rst_pixel_tick", int'(pixel_tick), 0);
      rst       = 1'b0;
      run       = 1'b1;
      have_prev = 1'b0;
      for (int p = 0; p < 400; p++) begin
         v = RGB_W'(p * 11 + 1);
         do_pixel(p, v, 12'hABC);
      end

      repeat (2) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
